// File: rtl/mmap_arb_pkg.sv
// mmap_arb_pkg: types shared by the two-requester memory-mapped arbiter.
//   NREQ        - number of requesters
//   req_idx_t   - requester index
//   arb_state_t - lock FSM state (IDLE, OWN0, OWN1)
package mmap_arb_pkg;
    localparam int NREQ = 2;
    typedef logic req_idx_t;
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;
endpackage

// File: rtl/mmap_dev.sv
// mmap_dev: shared downstream memory-mapped slave bus.
//   addr/wd/we - driven by the arbiter (master)
//   rd         - read data returned combinationally by the slave
interface mmap_dev;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        we;
    modport master(output addr, output wd, output we, input rd);
    modport slave(input addr, input wd, input we, output rd);
endinterface

// File: rtl/mmap_arb_pick.sv
// mmap_arb_pick: combinational one-hot grant picker.
//   valid_i   - per-requester request
//   rr_last_i - index granted most recently (loses the next contention)
//   locked_i  - a requester owns the bus; only owner_i may be granted
//   owner_i   - index of the lock owner
//   grant_o   - one-hot grant, zero when nothing is grantable
module mmap_arb_pick
    import mmap_arb_pkg::*;
(
    input  logic [NREQ-1:0] valid_i,
    input  req_idx_t        rr_last_i,
    input  logic            locked_i,
    input  req_idx_t        owner_i,
    output logic [NREQ-1:0] grant_o
);
    assign grant_o = locked_i ? (valid_i & (owner_i ? 2'b10 : 2'b01))
                   : (&valid_i ? (rr_last_i ? 2'b01 : 2'b10) : valid_i);
endmodule

// File: rtl/mmap_arbiter.sv
// mmap_arbiter: two-requester round-robin arbiter onto one memory-mapped slave.
//   clk, reset           - clock, asynchronous active-high reset
//   req_valid/we/addr/wd - per-requester access (held until req_ready)
//   req_lock             - keep the grant after this access (MMAP_ARB_LOCK_EN only)
//   req_ready            - combinational accept for the granted requester
//   resp_valid/resp_rd   - one-cycle response pulse with read data sampled at grant
//   iface                - shared downstream slave
// Define MMAP_ARB_LOCK_EN to add bus locking with a forced release after
// LOCK_MAX consecutive locked grants.
module mmap_arbiter
    import mmap_arb_pkg::*;
#(
    parameter int LOCK_MAX = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_we,
    input  logic [NREQ-1:0][31:0] req_addr,
    input  logic [NREQ-1:0][31:0] req_wd,
`ifdef MMAP_ARB_LOCK_EN
    input  logic [NREQ-1:0]       req_lock,
`endif
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       resp_valid,
    output logic [31:0]           resp_rd,
    mmap_dev.master               iface
);
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] resp_valid_q;
    logic [31:0]     resp_rd_q;
    req_idx_t        rr_last_q;
    req_idx_t        gidx;
    req_idx_t        owner;
    logic            locked;

    mmap_arb_pick u_pick (
        .valid_i  (req_valid),
        .rr_last_i(rr_last_q),
        .locked_i (locked),
        .owner_i  (owner),
        .grant_o  (grant)
    );

    assign gidx       = grant[1];
    assign req_ready  = grant;
    assign resp_valid = resp_valid_q;
    assign resp_rd    = resp_rd_q;
    assign iface.addr = |grant ? req_addr[gidx] : '0;
    assign iface.wd   = |grant ? req_wd[gidx] : '0;
    assign iface.we   = |grant & req_we[gidx];

    // rr_last resets to 1 so requester 0 wins the first contention
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_last_q    <= 1'b1;
            resp_valid_q <= '0;
            resp_rd_q    <= '0;
        end else begin
            resp_valid_q <= grant;
            if (|grant) begin
                rr_last_q <= gidx;
                resp_rd_q <= iface.rd;
            end
        end
    end

`ifdef MMAP_ARB_LOCK_EN
    localparam int CW = $clog2(LOCK_MAX + 1);
    arb_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

    assign cnt_inc = cnt_q + 1'b1;
    assign locked  = state_q != IDLE;
    assign owner   = state_q == OWN1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Every grant either (re)enters ownership with one more locked grant
    // counted, or drops to IDLE: on unlock, or once LOCK_MAX is reached.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (|grant) begin
            state_d = (req_lock[gidx] && cnt_inc < CW'(LOCK_MAX)) ? (gidx ? OWN1 : OWN0) : IDLE;
            cnt_d   = state_d == IDLE ? '0 : cnt_inc;
        end
    end
`else
    // LOCK_MAX has no effect without locking
    localparam int LOCK_MAX_UNUSED = LOCK_MAX;
    assign locked = 1'b0;
    assign owner  = 1'b0;
`endif
endmodule

// File: tb/tb_mmap_arbiter.sv
// tb_mmap_arbiter: scoreboard bench for mmap_arbiter with a 4-word slave model.
module tb_mmap_arbiter;
    import mmap_arb_pkg::*;

    typedef struct {
        logic [1:0]  idx;
        logic [31:0] rd;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       req_valid, req_we, req_lock, req_ready, resp_valid;
    logic [1:0][31:0] req_addr, req_wd;
    logic [31:0]      resp_rd;
    logic [31:0]      mem [4];
    logic [31:0]      last_rd = '0;
    logic             mon_en = 1'b0;
    exp_t             sb[$];
    exp_t             mon_e;
    int               errs = 0;
    int               checks = 0;

    mmap_dev bus();

    mmap_arbiter #(.LOCK_MAX(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wd    (req_wd),
`ifdef MMAP_ARB_LOCK_EN
        .req_lock  (req_lock),
`endif
        .req_ready (req_ready),
        .resp_valid(resp_valid),
        .resp_rd   (resp_rd),
        .iface     (bus)
    );

    always #5 clk = ~clk;

    assign bus.rd = mem[bus.addr[3:2]];

    always @(posedge clk) begin
        if (reset) begin
            mem[0] <= 32'h1111_0000;
            mem[1] <= 32'h2222_0004;
            mem[2] <= 32'h3333_0008;
            mem[3] <= 32'h4444_000C;
        end else if (bus.we) begin
            mem[bus.addr[3:2]] <= bus.wd;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] g);
        logic [31:0] ea, ed;
        @(negedge clk);
        req_valid   = v;
        req_we      = we;
        req_lock    = lk;
        req_addr[0] = a0;
        req_addr[1] = a1;
        req_wd[0]   = d0;
        req_wd[1]   = d1;
        #1;
        ea = g[0] ? a0 : g[1] ? a1 : 32'h0;
        ed = g[0] ? d0 : g[1] ? d1 : 32'h0;
        check("ready", 32'(req_ready), 32'(g));
        check("addr", bus.addr, ea);
        check("wd", bus.wd, ed);
        check("we", 32'(bus.we), 32'(|(g & we)));
        if (|g) sb.push_back('{g, mem[ea[3:2]]});
    endtask

    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("resp_valid", 32'(resp_valid), 32'(mon_e.idx));
                check("resp_rd", resp_rd, mon_e.rd);
                last_rd = mon_e.rd;
            end else begin
                check("resp_idle", 32'(resp_valid), 32'h0);
                check("rd_hold", resp_rd, last_rd);
            end
        end
    end

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_lock  = '0;
        req_addr  = '0;
        req_wd    = '0;
        #1;
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_rd", resp_rd, 32'h0);
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;
        // contention after reset: 0 first, then 1
        step(2'b11, 2'b00, 2'b00, 32'h0, 32'h4, 0, 0, 2'b01);
        step(2'b10, 2'b00, 2'b00, 32'h0, 32'h4, 0, 0, 2'b10);
        step(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00);
        // requester 1 alone writes 0xA5 to 0x0
        step(2'b10, 2'b10, 2'b00, 0, 32'h0, 0, 32'hA5, 2'b10);
        step(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00);
        // sustained contention alternates, starting with 0 after the grant to 1
        for (int i = 0; i < 6; i++)
            step(2'b11, 2'b00, 2'b00, (i == 0) ? 32'h0 : 32'h8, 32'hC, 0, 0, (i % 2 == 1) ? 2'b10 : 2'b01);
        step(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00);
`ifdef MMAP_ARB_LOCK_EN
        // requester 0 locks; requester 1 blocked even when 0 is idle
        step(2'b11, 2'b00, 2'b01, 32'h0, 32'h4, 0, 0, 2'b01);
        step(2'b10, 2'b00, 2'b00, 32'h0, 32'h4, 0, 0, 2'b00);
        step(2'b11, 2'b00, 2'b01, 32'h8, 32'h4, 0, 0, 2'b01);
        step(2'b11, 2'b00, 2'b00, 32'hC, 32'h4, 0, 0, 2'b01);
        step(2'b11, 2'b00, 2'b00, 32'h0, 32'h4, 0, 0, 2'b10);
        // held lock is forced off after 4 grants
        for (int i = 0; i < 4; i++)
            step(2'b11, 2'b00, 2'b01, 32'(i * 4), 32'h8, 0, 0, 2'b01);
        step(2'b11, 2'b00, 2'b01, 32'h0, 32'h8, 0, 0, 2'b10);
        step(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00);
        // requester 1 takes ownership, then contention stays with it
        step(2'b10, 2'b00, 2'b10, 32'h0, 32'h4, 0, 0, 2'b10);
        step(2'b11, 2'b00, 2'b10, 32'h0, 32'h8, 0, 0, 2'b10);
`else
        step(2'b10, 2'b00, 2'b10, 32'h0, 32'h4, 0, 0, 2'b10);
        step(2'b11, 2'b00, 2'b10, 32'h0, 32'h8, 0, 0, 2'b01);
`endif
        // reset while a response pulse is out (and, with locking, in OWN1)
        @(posedge clk);
        #3;
        mon_en    = 1'b0;
        reset     = 1'b1;
        req_valid = 2'b00;
        #1;
        check("mid_rst_resp_valid", 32'(resp_valid), 32'h0);
        check("mid_rst_resp_rd", resp_rd, 32'h0);
        sb.delete();
        last_rd = '0;
        @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;
        step(2'b11, 2'b00, 2'b00, 32'h4, 32'h8, 0, 0, 2'b01);
        step(2'b10, 2'b00, 2'b00, 32'h4, 32'h8, 0, 0, 2'b10);
        step(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00);
        @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/mmap_arbiter.md
MMAP_ARBITER -- requirements
Module: mmap_arbiter

Interface
REQ-001 The module SHALL take one parameter: LOCK_MAX, default 8, the maximum number of consecutive locked grants to one requester before a forced release.
REQ-002 The module SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have the port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have the port req_valid, input, 2 bits: per-requester access request.
REQ-005 The module SHALL have the port req_we, input, 2 bits: per-requester write enable.
REQ-006 The module SHALL have the port req_addr, input, 2x32 bits: per-requester byte address.
REQ-007 The module SHALL have the port req_wd, input, 2x32 bits: per-requester write data.
REQ-008 The module SHALL have the port req_lock, input, 2 bits: hold grant after this access; port present only with MMAP_ARB_LOCK_EN.
REQ-009 The module SHALL have the port req_ready, output, 2 bits: the access is accepted this cycle.
REQ-010 The module SHALL have the port resp_valid, output, 2 bits: one-cycle response pulse.
REQ-011 The module SHALL have the port resp_rd, output, 32 bits: registered read data.
REQ-012 The module SHALL have the port iface, mmap_dev.master, addr/wd/we/rd: the shared downstream slave.

Function
REQ-013 The arbiter SHALL grant at most one requester per cycle, combinationally; req_ready of the granted requester SHALL be 1 in that same cycle, and 0 for the other requester.
REQ-014 With exactly one req_valid set, the arbiter SHALL grant that requester.
REQ-015 With both req_valid set and no lock held, the arbiter SHALL grant the requester other than the last granted one (round-robin pointer rr_last, 1 bit).
REQ-016 In a grant cycle, iface.addr/wd/we SHALL equal the granted requester's req_addr/req_wd/req_we.
REQ-017 With no grant, iface.we SHALL be 0, and iface.addr and iface.wd SHALL be 0.
REQ-018 A non-granted requester SHALL hold req_valid and its payload stable; the arbiter SHALL not buffer requests.
REQ-019 In the cycle after every accepted access, read or write, the arbiter SHALL pulse resp_valid[i] for exactly one cycle for the requester i that was granted, with resp_rd = iface.rd sampled at grant.
REQ-020 resp_rd SHALL hold its value between responses.
REQ-021 rr_last SHALL update to the granted index on every grant; sustained contention SHALL alternate 0,1,0,1.
REQ-022 Lock FSM states SHALL be IDLE, OWN0, OWN1.
REQ-023 IDLE SHALL move to OWNi on a grant to i with req_lock[i]=1.
REQ-024 In OWNi, only requester i SHALL be grantable; the other requester's req_ready SHALL be 0 even if the bus is idle.
REQ-025 OWNi SHALL move to IDLE on a grant to i with req_lock[i]=0.
REQ-026 OWNi SHALL also move to IDLE when the lock counter reaches LOCK_MAX locked grants; that release SHALL be forced, and rr_last=i then gives the other requester priority.
REQ-027 The lock counter SHALL be $clog2(LOCK_MAX+1) bits wide, clear in IDLE, and increment per locked grant.
REQ-028 In OWNi with req_valid[i]=0, the state SHALL hold and the counter SHALL not advance.

Reset
REQ-029 Asserting reset SHALL immediately force: req_ready=0 only via the state, resp_valid=0, resp_rd=0, rr_last=1 (requester 0 wins first contention), FSM=IDLE, lock counter=0.
REQ-030 Reset mid-lock or mid-response SHALL discard the lock and any pending response pulse.

Configuration
REQ-031 With MMAP_ARB_LOCK_EN defined, the module SHALL have the req_lock port, the FSM and the lock counter.
REQ-032 Without MMAP_ARB_LOCK_EN, the module SHALL have no req_lock port and no FSM; arbitration SHALL be pure round-robin as in REQ-013 to REQ-021, and LOCK_MAX SHALL be ignored.

Structure
REQ-033 Package mmap_arb_pkg SHALL hold: NREQ=2, typedef req_idx_t (1 bit), and enum arb_state_t {IDLE, OWN0, OWN1}.
REQ-034 The module SHALL contain one sub-module, mmap_arb_pick: a combinational picker (valid[1:0], rr_last, owner/locked -> grant one-hot).

Verification
REQ-035 Scenario 1: after reset, both requesters valid reading 0x0 and 0x4 -> grant 0 first, then 1; resp_valid = 01 then 10, each carrying the matching slave data.
REQ-036 Scenario 2: requester 1 alone writes 0xA5 to 0x0 -> req_ready[1]=1 the same cycle, iface.we=1, resp_valid[1] the next cycle, rr_last=1.
REQ-037 Scenario 3: both requesters valid for 6 cycles -> grants 0,1,0,1,0,1.
REQ-038 Scenario 4 (LOCK_EN): requester 0 locks, requester 1 requests continuously, requester 0 unlocks on its 3rd access -> requester 1 is granted in the cycle after that access.
REQ-039 Scenario 5 (LOCK_EN, LOCK_MAX=4): requester 0 holds lock -> forced release after 4 grants, then requester 1 is granted.
REQ-040 Scenario 6: reset asserted while in OWN1 -> IDLE immediately, resp_valid=00, and the next contention grants requester 0.
